// File: rtl/rv_mem_arbiter.sv
// rv_mem_arbiter: round-robin share of one single-port synchronous RAM between
// the fetch port and the data port, one access at a time through IDLE/ISSUE/WAIT/RESP.
module rv_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            i_req_i,
  input  logic [AW-1:0]   i_addr_i,
  output logic [DW-1:0]   i_data_o,
  output logic            i_ack_o,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [AW-1:0]   d_addr_i,
  input  logic [DW-1:0]   d_wdata_i,
  input  logic [DW/8-1:0] d_be_i,
  output logic [DW-1:0]   d_rdata_o,
  output logic            d_ack_o,
  output logic            m_en_o,
  output logic            m_we_o,
  output logic [DW/8-1:0] m_be_o,
  output logic [AW-1:0]   m_addr_o,
  output logic [DW-1:0]   m_wdata_o,
  input  logic [DW-1:0]   m_rdata_i,
  output logic            busy_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t     r_state;
  logic [2:0] r_cnt;
  logic       r_gnt_d;
  logic       r_last_d;
  logic       w_pick_d;
  // data wins when alone, or on conflict when fetch was served last
  assign w_pick_d = d_req_i & (~i_req_i | ~r_last_d);
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_gnt_d   <= 1'b0;
      r_last_d  <= 1'b1;
      i_data_o  <= '0;
      d_rdata_o <= '0;
      i_ack_o   <= 1'b0;
      d_ack_o   <= 1'b0;
      m_en_o    <= 1'b0;
      m_we_o    <= 1'b0;
      m_be_o    <= '0;
      m_addr_o  <= '0;
      m_wdata_o <= '0;
      busy_o    <= 1'b0;
    end else begin
      i_ack_o   <= 1'b0;
      d_ack_o   <= 1'b0;
      m_en_o    <= 1'b0;
      m_we_o    <= 1'b0;
      m_be_o    <= '0;
      m_addr_o  <= '0;
      m_wdata_o <= '0;
      case (r_state)
        IDLE: if (i_req_i | d_req_i) begin
          r_state   <= ISSUE;
          busy_o    <= 1'b1;
          r_gnt_d   <= w_pick_d;
          r_last_d  <= w_pick_d;
          m_en_o    <= 1'b1;
          m_we_o    <= w_pick_d & d_we_i;
          m_be_o    <= w_pick_d ? d_be_i : '1;
          m_addr_o  <= (w_pick_d ? d_addr_i : i_addr_i) & ~AW'(3);
          m_wdata_o <= w_pick_d ? d_wdata_i : '0;
        end
        ISSUE: if (m_we_o) begin
          r_state <= RESP;
          d_ack_o <= r_gnt_d;
          i_ack_o <= ~r_gnt_d;
        end else begin
          r_cnt   <= 3'(MEM_LAT - 1);
          r_state <= WAIT;
        end
        WAIT: if (|r_cnt) r_cnt <= r_cnt - 3'd1;
        else begin
          r_state <= RESP;
          if (r_gnt_d) begin
            d_rdata_o <= m_rdata_i;
            d_ack_o   <= 1'b1;
          end else begin
            i_data_o <= m_rdata_i;
            i_ack_o  <= 1'b1;
          end
        end
        RESP: begin
          r_state <= IDLE;
          busy_o  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rv_mem_arbiter.sv
// tb_rv_mem_arbiter: directed checks of rv_mem_arbiter at MEM_LAT=1 (u1) and MEM_LAT=3 (u3)
// against behavioural RAMs, with a scoreboard of expected acks for u3.
module tb_rv_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        i_req1 = 1'b0;
  logic [31:0] i_addr1 = '0;
  logic [31:0] i_data1, d_rdata1, m_addr1, m_wdata1, m_rdata1;
  logic        i_ack1, d_ack1, m_en1, m_we1, busy1;
  logic [3:0]  m_be1;

  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic [31:0] i_data, d_rdata, m_addr, m_wdata, m_rdata;
  logic        i_ack, d_ack, m_en, m_we, busy;
  logic [3:0]  m_be;

  rv_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u1 (
    .clk_i(clk), .rst_n_i(rst_n),
    .i_req_i(i_req1), .i_addr_i(i_addr1), .i_data_o(i_data1), .i_ack_o(i_ack1),
    .d_req_i(1'b0), .d_we_i(1'b0), .d_addr_i(32'h0), .d_wdata_i(32'h0), .d_be_i(4'h0),
    .d_rdata_o(d_rdata1), .d_ack_o(d_ack1),
    .m_en_o(m_en1), .m_we_o(m_we1), .m_be_o(m_be1), .m_addr_o(m_addr1),
    .m_wdata_o(m_wdata1), .m_rdata_i(m_rdata1), .busy_o(busy1)
  );

  rv_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) u3 (
    .clk_i(clk), .rst_n_i(rst_n),
    .i_req_i(i_req), .i_addr_i(i_addr), .i_data_o(i_data), .i_ack_o(i_ack),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_be_i(d_be),
    .d_rdata_o(d_rdata), .d_ack_o(d_ack),
    .m_en_o(m_en), .m_we_o(m_we), .m_be_o(m_be), .m_addr_o(m_addr),
    .m_wdata_o(m_wdata), .m_rdata_i(m_rdata), .busy_o(busy)
  );

  // u1 RAM: read-only, one-cycle latency
  always @(posedge clk)
    m_rdata1 <= (m_en1 && !m_we1) ? ((m_addr1 == 32'h0) ? 32'h00500093 : 32'h00a00113) : 32'h0;

  // u3 RAM: byte-writable, three-cycle read pipe that carries zero when idle
  logic [31:0] mem3 [0:15];
  logic [31:0] pipe [0:2];
  logic        mem_init = 1'b0;
  assign m_rdata = pipe[2];
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int k = 0; k < 16; k++) mem3[k] <= 32'h0;
      mem3[0]  <= 32'h00000013;
      mem3[1]  <= 32'h00100113;
      mem3[3]  <= 32'h0BADF00D;
      mem3[4]  <= 32'hDEADBEEF;
      mem_init <= 1'b1;
    end else if (m_en && m_we) begin
      for (int b = 0; b < 4; b++)
        if (m_be[b]) mem3[m_addr[5:2]][8*b +: 8] <= m_wdata[8*b +: 8];
    end
    pipe[0] <= (m_en && !m_we) ? mem3[m_addr[5:2]] : 32'h0;
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic        pd;
    logic        rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t q[$];
  exp_t e;

  always @(negedge clk)
    if (i_ack || d_ack) begin
      chk("ack_excl", {63'h0, i_ack & d_ack}, 64'h0);
      chk("ack_expected", {63'h0, q.size() != 0}, 64'h1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("ack_port", {63'h0, d_ack}, {63'h0, e.pd});
        chk("ack_cycle", 64'(cyc), 64'(e.cyc));
        if (e.rd) chk("ack_rdata", {32'h0, e.pd ? d_rdata : i_data}, {32'h0, e.data});
      end
    end

  task automatic acc(input logic pd, input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input logic [31:0] ed, input logic drop);
    int t;
    int n;
    @(negedge clk);
    t = cyc;
    if (pd) begin
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
    end else begin
      i_req = 1'b1; i_addr = a;
    end
    q.push_back('{pd, !we, ed, t + 2 + (we ? 0 : 3)});
    @(negedge clk);
    chk("iss_en", {63'h0, m_en}, 64'h1);
    chk("iss_addr", {32'h0, m_addr}, {32'h0, a & ~32'h3});
    chk("iss_we", {63'h0, m_we}, {63'h0, we});
    chk("iss_be", {60'h0, m_be}, {60'h0, pd ? be : 4'hf});
    if (we) chk("iss_wdata", {32'h0, m_wdata}, {32'h0, wd});
    if (drop) begin
      d_req = 1'b0; i_req = 1'b0;
      d_addr = ~a; d_wdata = ~wd; d_be = ~be;
    end
    @(negedge clk);
    chk("post_iss_quiet", {27'h0, m_en, m_we, m_be, m_addr}, 64'h0);
    n = 2;
    while (!(pd ? d_ack : i_ack) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ack_seen", {63'h0, pd ? d_ack : i_ack}, 64'h1);
    d_req = 1'b0; i_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    int n;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", {i_data, d_rdata}, 64'h0);
    chk("rst_mem", {m_addr, m_wdata}, 64'h0);
    chk("rst_ctl", {55'h0, i_ack, d_ack, m_en, m_we, m_be, busy}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", {63'h0, busy}, 64'h0);

    // MEM_LAT=1 fetches: strobe in T+1, ack in T+3; second address exercises [1:0] masking
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      t = cyc;
      i_req1 = 1'b1;
      i_addr1 = (k == 0) ? 32'h0 : 32'h6;
      @(negedge clk);
      chk("l1_en", {63'h0, m_en1}, 64'h1);
      chk("l1_addr", {32'h0, m_addr1}, (k == 0) ? 64'h0 : 64'h4);
      n = 0;
      while (!i_ack1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("l1_ack_cycle", 64'(cyc - t), 64'd3);
      chk("l1_data", {32'h0, i_data1}, (k == 0) ? 64'h00500093 : 64'h00a00113);
      i_req1 = 1'b0;
    end

    acc(1'b0, 1'b0, 32'h4, 32'h0, 4'hf, 32'h00100113, 1'b0);
    acc(1'b1, 1'b0, 32'h10, 32'h0, 4'hf, 32'hDEADBEEF, 1'b0);
    chk("i_data_hold", {32'h0, i_data}, 64'h00100113);
    acc(1'b1, 1'b1, 32'h8, 32'h12345678, 4'b0011, 32'h0, 1'b0);
    chk("wr_keeps_rdata", {32'h0, d_rdata}, 64'hDEADBEEF);
    acc(1'b1, 1'b0, 32'h8, 32'h0, 4'hf, 32'h00005678, 1'b0);

    // both held: I,D,I,D every MEM_LAT+3 cycles starting with fetch
    @(negedge clk);
    t = cyc;
    i_req = 1'b1; i_addr = 32'h0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_be = 4'hf;
    q.push_back('{1'b0, 1'b1, 32'h00000013, t + 5});
    q.push_back('{1'b1, 1'b1, 32'hDEADBEEF, t + 11});
    q.push_back('{1'b0, 1'b1, 32'h00000013, t + 17});
    q.push_back('{1'b1, 1'b1, 32'hDEADBEEF, t + 23});
    repeat (23) @(negedge clk);
    i_req = 1'b0; d_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("rr_drained", 64'(q.size()), 64'h0);

    acc(1'b1, 1'b1, 32'h13, 32'hCAFEF00D, 4'hf, 32'h0, 1'b1);
    acc(1'b1, 1'b0, 32'h10, 32'h0, 4'hf, 32'hCAFEF00D, 1'b0);

    // reset in WAIT aborts the read with no ack and clears everything
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_be = 4'hf;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", {63'h0, busy}, 64'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_data", {i_data, d_rdata}, 64'h0);
    chk("mid_rst_mem", {m_addr, m_wdata}, 64'h0);
    chk("mid_rst_ctl", {55'h0, i_ack, d_ack, m_en, m_we, m_be, busy}, 64'h0);
    d_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    t = cyc;
    i_req = 1'b1; i_addr = 32'h4;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'hC; d_be = 4'hf;
    q.push_back('{1'b0, 1'b1, 32'h00100113, t + 5});
    q.push_back('{1'b1, 1'b1, 32'h0BADF00D, t + 11});
    repeat (11) @(negedge clk);
    i_req = 1'b0; d_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("final_drained", 64'(q.size()), 64'h0);
    chk("final_idle", {63'h0, busy}, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rv_mem_arbiter.md
Name: rv_mem_arbiter

Overview:
Shares one single-port synchronous memory between the nano_rv32i instruction-fetch port and its data port.
- Both requesters use a level request / one-cycle acknowledge handshake.
- Arbitration is round-robin on conflict.
- The block sequences each memory access through a fixed FSM, absorbs a configurable memory read latency, and returns registered read data.
- It sits between the core and the unified program/data RAM at SoC top level.

Parameters:
AW, 32, address width (bits)
DW, 32, data width (bits); byte enables are DW/8 wide
MEM_LAT, 1, memory read latency in cycles from the m_en_o cycle to m_rdata_i valid; legal range 1..7

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
i_req_i  in  1  instruction fetch request (read only), level
i_addr_i  in  AW  fetch address
i_data_o  out  DW  fetched instruction word
i_ack_o  out  1  fetch complete, one-cycle pulse
d_req_i  in  1  data request, level
d_we_i  in  1  1 = write, 0 = read
d_addr_i  in  AW  data address
d_wdata_i  in  DW  write data
d_be_i  in  DW/8  write byte enables
d_rdata_o  out  DW  data read result
d_ack_o  out  1  data access complete, one-cycle pulse
m_en_o  out  1  memory access strobe
m_we_o  out  1  memory write enable
m_be_o  out  DW/8  memory byte enables
m_addr_o  out  AW  memory byte address, bits [1:0] forced to 0
m_wdata_o  out  DW  memory write data
m_rdata_i  in  DW  memory read data
busy_o  out  1  high when FSM is not IDLE

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0.
  - FSM = IDLE.
  - last_grant = DATA, so the first conflict goes to instruction.
  - Latency counter = 0.
  - Read-data registers = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Requests are sampled here only.
  - If exactly one request is high, grant it.
  - If both are high, grant the port not equal to last_grant, then update last_grant.
  - On grant, register the winner's addr, we, wdata and be, then go to ISSUE.
  - The instruction port always registers we=0 and be=all ones.
- ISSUE (exactly 1 cycle):
  - m_en_o=1; m_we_o, m_be_o, m_addr_o and m_wdata_o are driven from the registers.
  - On a write, go to RESP.
  - On a read, load cnt=MEM_LAT-1 and go to WAIT.
- WAIT:
  - If cnt≠0, decrement.
  - If cnt==0, capture m_rdata_i into i_data_o or d_rdata_o (the granted port's register) and go to RESP.
  - m_en_o=0 throughout.
- RESP (exactly 1 cycle):
  - Ack of the granted port = 1, then go to IDLE.
  - Read-data outputs hold their value until the next capture for the same port.
- Timing, with a request first seen in IDLE cycle T:
  - Read: ack in cycle T+2+MEM_LAT.
  - Write: ack in cycle T+2.
  - Peak throughput: one read per MEM_LAT+3 cycles; one write per 3 cycles.
- m_we_o, m_be_o, m_addr_o and m_wdata_o are 0 whenever m_en_o=0.
- Payload is registered at grant. Requester changes after grant are ignored, and dropping req after grant still completes the access (ack is still pulsed).
- A requester that keeps req high in the cycle after its ack issues a new access.
- Only one ack is ever high per cycle; i_ack_o and d_ack_o are never simultaneous.
- Reset mid-operation:
  - The access is aborted and no ack is issued.
  - If reset arrives before ISSUE, no memory strobe is issued.
  - If it arrives in ISSUE, the strobe is cut asynchronously.
- Address bits [1:0] are ignored. No misalignment error is raised.

Test Plan:
1. MEM_LAT=1. i_req with i_addr=0x0, memory word[0]=0x00500093 -> m_en_o in T+1 with m_addr_o=0x0; i_ack_o in T+3; i_data_o=0x00500093.
2. MEM_LAT=3. d_req read at 0x10, memory holds 0xDEADBEEF -> d_ack_o in T+5; d_rdata_o=0xDEADBEEF; i_data_o unchanged.
3. d_req write: addr 0x8, wdata 0x12345678, be 4'b0011 -> single m_en_o cycle with m_we_o=1, m_be_o=0011; d_ack_o in T+2; a readback returns 0x00005678 over initial 0.
4. i_req and d_req both held continuously -> grants alternate I,D,I,D starting with I; each ack is exactly one cycle; acks are never simultaneous.
5. d_req write with d_addr=0x13 -> m_addr_o=0x10.
6. Assert rst_n_i during a WAIT of a MEM_LAT=3 read -> all outputs 0 immediately; no ack; after release, a new i_req completes normally with last_grant reset to DATA.
